// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Writeback controller for the 32x32 integer register file. The execute
// pipeline and the load unit share the single write port through a two-way
// round-robin arbiter with valid/ready handshakes. The winning write is
// registered for one cycle before it reaches the file. A 32-bit scoreboard
// tracks destinations with outstanding loads so the issue stage can stall.
//
// Arbitration pointer states:
//   state  | meaning
//   FAV_EX | execute wins the next tie
//   FAV_LD | load wins the next tie (reset state)
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ex_valid/ex_ready/ex_rd/ex_value   execute result handshake
//   ld_valid/ld_ready/ld_rd/ld_value   load data handshake
//   issue_load, issue_rd         load dispatch, marks issue_rd pending
//   q_rs1, q_rs2, q_rd           scoreboard queries
//   rs1_busy, rs2_busy, rd_busy  pending status of the queried registers
//   wen, rd_addr, rd_value       registered register-file write port

module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_value,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_value,
    input  logic        issue_load,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    input  logic [4:0]  q_rd,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rd_busy,
    output logic        wen,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_value
);

    typedef enum logic {
        FAV_EX = 1'b0,
        FAV_LD = 1'b1
    } fav_t;

    fav_t        fav_q;
    fav_t        fav_d;
    logic        ex_xfer;
    logic        ld_xfer;
    logic [31:0] pending_q;
    logic [31:0] pending_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            fav_q <= FAV_LD;
        end else begin
            fav_q <= fav_d;
        end
    end

    // Grant and next pointer. Whoever wins hands priority to the other side,
    // which covers both the single-requester and the tie cases.
    always_comb begin
        ex_ready = 1'b0;
        ld_ready = 1'b0;
        fav_d    = fav_q;
        if (!rst) begin
            if (ex_valid && ld_valid) begin
                if (fav_q == FAV_LD) begin
                    ld_ready = 1'b1;
                end else begin
                    ex_ready = 1'b1;
                end
            end else begin
                ex_ready = ex_valid;
                ld_ready = ld_valid;
            end
        end
        if (ex_ready) begin
            fav_d = FAV_LD;
        end else if (ld_ready) begin
            fav_d = FAV_EX;
        end
    end

    assign ex_xfer = ex_valid && ex_ready;
    assign ld_xfer = ld_valid && ld_ready;

    // Writes to x0 complete the handshake but never reach the file, and the
    // address/data registers keep their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen      <= 1'b0;
            rd_addr  <= 5'd0;
            rd_value <= 32'd0;
        end else begin
            wen <= 1'b0;
            if (ex_xfer && (ex_rd != 5'd0)) begin
                wen      <= 1'b1;
                rd_addr  <= ex_rd;
                rd_value <= ex_value;
            end else if (ld_xfer && (ld_rd != 5'd0)) begin
                wen      <= 1'b1;
                rd_addr  <= ld_rd;
                rd_value <= ld_value;
            end
        end
    end

    // Clear is applied before set so a load dispatched to the same register
    // that is retiring this cycle keeps the bit pending.
    always_comb begin
        pending_d = pending_q;
        if (ld_xfer) begin
            pending_d[ld_rd] = 1'b0;
        end
        if (issue_load) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 32'd0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rs1_busy = pending_q[q_rs1];
    assign rs2_busy = pending_q[q_rs2];
    assign rd_busy  = pending_q[q_rd];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [31:0] ex_value;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_value;
    logic        issue_load;
    logic [4:0]  issue_rd;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic [4:0]  q_rd;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_busy;
    logic        wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_value;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: who gets the next tie, which registers are
    // awaiting load data, and what the write port should show.
    bit          m_fav_ld;
    bit          m_pend [32];
    bit          m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_value;
    int          last_grant;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_value(ex_value),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_value(ld_value),
        .issue_load(issue_load), .issue_rd(issue_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
        .wen(wen), .rd_addr(rd_addr), .rd_value(rd_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0 = nobody, 1 = execute, 2 = load
    function automatic int exp_grant();
        if (rst) return 0;
        if (ex_valid && ld_valid) return m_fav_ld ? 2 : 1;
        if (ex_valid) return 1;
        if (ld_valid) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_fav_ld = 1'b1;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_wen   = 1'b0;
        m_addr  = 5'd0;
        m_value = 32'd0;
    endtask

    // Advance one clock and apply the behavioural rules to the model.
    task automatic tick();
        int g;
        g = exp_grant();
        last_grant = g;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_wen = 1'b0;
            if (g == 1) begin
                m_fav_ld = 1'b1;
                if (ex_rd != 0) begin m_wen = 1'b1; m_addr = ex_rd; m_value = ex_value; end
            end else if (g == 2) begin
                m_fav_ld = 1'b0;
                m_pend[ld_rd] = 1'b0;
                if (ld_rd != 0) begin m_wen = 1'b1; m_addr = ld_rd; m_value = ld_value; end
            end
            if (issue_load && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_valid = 1'b1; ld_valid = 1'b1;
        #1;
        n_chk++; if (ex_ready !== 1'b0) begin n_err++; $display("FAIL reset_ex_ready got=%b exp=0", ex_ready); end
        n_chk++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
        tick();
        tick();
        q_rs1 = 5'd3; q_rs2 = 5'd17; q_rd = 5'd31;
        #1;
        n_chk++; if (wen !== 1'b0) begin n_err++; $display("FAIL reset_wen got=%b exp=0", wen); end
        n_chk++; if (rd_addr !== 5'd0) begin n_err++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        n_chk++; if (rd_value !== 32'd0) begin n_err++; $display("FAIL reset_rd_value got=%h exp=0", rd_value); end
        n_chk++; if ({rs1_busy, rs2_busy, rd_busy} !== 3'b000)
            begin n_err++; $display("FAIL reset_busy got=%b exp=000", {rs1_busy, rs2_busy, rd_busy}); end
        rst = 1'b0;
        #1;
        n_chk++; if (ld_ready !== 1'b1 || ex_ready !== 1'b0)
            begin n_err++; $display("FAIL reset_first_tie got ld=%b ex=%b exp ld=1 ex=0", ld_ready, ex_ready); end
        ex_valid = 1'b0; ld_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_ex();
        ex_valid = 1'b1; ex_rd = 5'd5; ex_value = 32'hDEADBEEF;
        #1;
        n_chk++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL single_ex_ready got=%b exp=1", ex_ready); end
        tick();
        ex_valid = 1'b0;
        n_chk++; if (wen !== 1'b1 || rd_addr !== 5'd5 || rd_value !== 32'hDEADBEEF)
            begin n_err++; $display("FAIL single_ex_wb got wen=%b addr=%0d val=%h exp 1/5/deadbeef", wen, rd_addr, rd_value); end
        tick();
        n_chk++; if (wen !== 1'b0) begin n_err++; $display("FAIL single_ex_wen_drop got=%b exp=0", wen); end
    endtask

    task automatic test_contention();
        logic [31:0] ldv;
        logic [31:0] exv;
        bit          exp_ld;
        ldv = 32'h11; exv = 32'h22;
        ld_rd = 5'd3; ex_rd = 5'd4;
        ld_valid = 1'b1; ex_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_value = ldv; ex_value = exv;
            exp_ld = (i % 2 == 0);
            #1;
            n_chk++; if (ld_ready !== exp_ld || ex_ready !== !exp_ld)
                begin n_err++; $display("FAIL contention_grant%0d got ld=%b ex=%b exp ld=%b", i, ld_ready, ex_ready, exp_ld); end
            tick();
            n_chk++; if (wen !== 1'b1 || rd_addr !== (exp_ld ? 5'd3 : 5'd4) || rd_value !== (exp_ld ? ldv : exv))
                begin n_err++; $display("FAIL contention_wb%0d got wen=%b addr=%0d val=%h exp addr=%0d val=%h",
                                        i, wen, rd_addr, rd_value, exp_ld ? 3 : 4, exp_ld ? ldv : exv); end
            if (exp_ld) ldv = ldv + 32'h100; else exv = exv + 32'h100;
        end
        ld_valid = 1'b0; ex_valid = 1'b0;
        tick();
    endtask

    task automatic test_x0();
        logic [31:0] prev_val;
        prev_val = rd_value;
        ld_valid = 1'b1; ld_rd = 5'd0; ld_value = 32'h1234;
        #1;
        n_chk++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL x0_ld_ready got=%b exp=1", ld_ready); end
        tick();
        ld_valid = 1'b0;
        n_chk++; if (wen !== 1'b0 || rd_addr !== 5'd4 || rd_value !== m_value || m_value !== prev_val)
            begin n_err++; $display("FAIL x0_write got wen=%b addr=%0d val=%h exp 0/4/%h", wen, rd_addr, rd_value, m_value); end
    endtask

    task automatic test_scoreboard();
        issue_load = 1'b1; issue_rd = 5'd7;
        q_rs1 = 5'd7; q_rs2 = 5'd7; q_rd = 5'd7;
        #1;
        n_chk++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL sb_no_forward got=%b exp=0", rs1_busy); end
        tick();
        issue_load = 1'b0;
        n_chk++; if ({rs1_busy, rs2_busy, rd_busy} !== 3'b111)
            begin n_err++; $display("FAIL sb_set got=%b exp=111", {rs1_busy, rs2_busy, rd_busy}); end
        ex_valid = 1'b1; ex_rd = 5'd7; ex_value = 32'h55;
        tick();
        ex_valid = 1'b0;
        n_chk++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sb_ex_no_clear got=%b exp=1", rs1_busy); end
        ld_valid = 1'b1; ld_rd = 5'd7; ld_value = 32'hCAFE0007;
        #1;
        n_chk++; if (ld_ready !== 1'b1 || rs1_busy !== 1'b1)
            begin n_err++; $display("FAIL sb_ld_xfer got ready=%b busy=%b exp 1/1", ld_ready, rs1_busy); end
        tick();
        ld_valid = 1'b0;
        n_chk++; if (rs1_busy !== 1'b0 || wen !== 1'b1 || rd_addr !== 5'd7 || rd_value !== 32'hCAFE0007)
            begin n_err++; $display("FAIL sb_clear got busy=%b wen=%b addr=%0d val=%h exp 0/1/7/cafe0007",
                                    rs1_busy, wen, rd_addr, rd_value); end
    endtask

    task automatic test_collision();
        issue_load = 1'b1; issue_rd = 5'd9;
        tick();
        ld_valid = 1'b1; ld_rd = 5'd9; ld_value = 32'h99;
        tick();
        ld_valid = 1'b0; issue_load = 1'b0;
        q_rd = 5'd9;
        #1;
        n_chk++; if (rd_busy !== 1'b1) begin n_err++; $display("FAIL collision_set_wins got=%b exp=1", rd_busy); end
        issue_load = 1'b1; issue_rd = 5'd0;
        tick();
        issue_load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            q_rs1 = 5'(i);
            #1;
            n_chk++; if (rs1_busy !== ((i == 9) ? 1'b1 : 1'b0))
                begin n_err++; $display("FAIL collision_mask reg=%0d got=%b exp=%b", i, rs1_busy, i == 9); end
        end
        ld_valid = 1'b1; ld_rd = 5'd9;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic test_random();
        int r;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!ex_valid || last_grant == 1) begin
                ex_valid = ($urandom_range(0, 2) != 0);
                ex_rd    = 5'($urandom_range(0, 31));
                ex_value = $urandom;
            end
            if (!ld_valid || last_grant == 2) begin
                ld_valid = ($urandom_range(0, 2) != 0);
                ld_rd    = 5'($urandom_range(0, 31));
                ld_value = $urandom;
            end
            r = $urandom_range(0, 31);
            issue_load = ($urandom_range(0, 2) == 0) && !m_pend[r];
            issue_rd   = 5'(r);
            q_rs1 = 5'($urandom_range(0, 31));
            q_rs2 = 5'($urandom_range(0, 31));
            q_rd  = 5'($urandom_range(0, 31));
            rst   = ($urandom_range(0, 39) == 0);
            #1;
            r = exp_grant();
            n_chk++; if (ex_ready !== (r == 1) || ld_ready !== (r == 2))
                begin n_err++; $display("FAIL rand_grant cyc=%0d got ex=%b ld=%b exp grant=%0d", cyc, ex_ready, ld_ready, r); end
            n_chk++; if (rs1_busy !== m_pend[q_rs1] || rs2_busy !== m_pend[q_rs2] || rd_busy !== m_pend[q_rd])
                begin n_err++; $display("FAIL rand_busy cyc=%0d got=%b%b%b exp=%b%b%b", cyc, rs1_busy, rs2_busy, rd_busy,
                                        m_pend[q_rs1], m_pend[q_rs2], m_pend[q_rd]); end
            tick();
            n_chk++; if (wen !== m_wen || rd_addr !== m_addr || rd_value !== m_value)
                begin n_err++; $display("FAIL rand_wb cyc=%0d got %b/%0d/%h exp %b/%0d/%h", cyc, wen, rd_addr, rd_value,
                                        m_wen, m_addr, m_value); end
        end
        rst = 1'b0; ex_valid = 1'b0; ld_valid = 1'b0; issue_load = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_rd = 5'd0; ex_value = 32'd0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_value = 32'd0;
        issue_load = 1'b0; issue_rd = 5'd0;
        q_rs1 = 5'd0; q_rs2 = 5'd0; q_rd = 5'd0;
        last_grant = 0;
        model_reset();
        test_reset();
        test_single_ex();
        test_contention();
        test_x0();
        test_scoreboard();
        test_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
